// File: rtl/d_ff_pipe.sv
// rtl/d_ff_pipe.sv - WIDTH-bit, DEPTH-stage stallable delay line with per-stage valid and occupancy count
//
// Optional feature macro: D_PIPE_PARITY_EN (adds par_inj / par_err and one parity bit per stage)
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    synchronous active-low reset (wins over flush and en)
//   en       1 = advance every stage, 0 = hold everything
//   flush    synchronous clear of all valid bits (data stages keep their values)
//   d_in     input data, captured into stage 0 on an enabled edge
//   d_valid  d_in carries a valid item
//   par_inj  (D_PIPE_PARITY_EN only) inverts the parity stored with the captured item
//   q        last-stage data, meaningful only while q_valid = 1
//   q_valid  last-stage valid
//   par_err  (D_PIPE_PARITY_EN only) last-stage data disagrees with its stored parity
//   count    number of valid items currently held in the stages
//   busy     count != 0
module d_ff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
`ifdef D_PIPE_PARITY_EN
    input  logic             par_inj,
    output logic             par_err,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    count,
    output logic             busy
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]    cnt;

    // Data stages shift on every enabled edge whether or not the slot is
    // valid; flush only touches the valid bits, so the data keeps its value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
            vld <= '0;
            cnt <= '0;
        end else if (flush) begin
            vld <= '0;
            cnt <= '0;
        end else if (en) begin
            stage[0] <= d_in;
            vld[0]   <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
                vld[i]   <= vld[i-1];
            end
            // Entry and exit in the same edge cancel; the count can never
            // leave 0..DEPTH because it tracks exactly the set valid bits.
            cnt <= cnt + CW'(d_valid) - CW'(vld[DEPTH-1]);
        end
    end

`ifdef D_PIPE_PARITY_EN
    logic [DEPTH-1:0] par;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            par <= '0;
        end else if (en) begin
            par[0] <= (^d_in) ^ par_inj;
            for (int i = 1; i < DEPTH; i++) begin
                par[i] <= par[i-1];
            end
        end
    end

    // Built only from last-stage registers, so it changes in step with q.
    assign par_err = vld[DEPTH-1] & ((^stage[DEPTH-1]) != par[DEPTH-1]);
`endif

    assign q       = stage[DEPTH-1];
    assign q_valid = vld[DEPTH-1];
    assign count   = cnt;
    assign busy    = (cnt != '0);

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb/tb_d_ff_pipe.sv - scoreboard bench for d_ff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0x5A)
module tb_d_ff_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RVAL  = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       flush;
    logic [7:0] d_in;
    logic       d_valid;
    logic [7:0] q;
    logic       q_valid;
    logic [2:0] count;
    logic       busy;
`ifdef D_PIPE_PARITY_EN
    logic       par_inj;
    logic       par_err;
`endif

    always #5 clk = ~clk;

    d_ff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d_in    (d_in),
        .d_valid (d_valid),
`ifdef D_PIPE_PARITY_EN
        .par_inj (par_inj),
        .par_err (par_err),
`endif
        .q       (q),
        .q_valid (q_valid),
        .count   (count),
        .busy    (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
        logic       pinj;
    } item_t;

    item_t sb[$];
    int    en_edges = 0;
    int    n_checks = 0;
    int    n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge, update the scoreboard with what the edge should do,
    // then compare outputs 1 ns after the edge.
    task automatic step(input logic rst, input logic fl, input logic e, input logic dv,
                        input logic [7:0] din, input logic pinj, input string tag);
        item_t it;
        logic  exp_qv;
        reset   = rst;
        flush   = fl;
        en      = e;
        d_valid = dv;
        d_in    = din;
`ifdef D_PIPE_PARITY_EN
        par_inj = pinj;
`endif
        @(posedge clk);
        #1;
        if (!rst || fl) begin
            sb.delete();
        end else if (e) begin
            en_edges++;
            if (sb.size() != 0 && sb[0].due < en_edges) void'(sb.pop_front());
            if (dv) begin
                it.data = din;
                it.due  = en_edges + DEPTH - 1;
                it.pinj = pinj;
                sb.push_back(it);
            end
        end
        exp_qv = (sb.size() != 0) && (sb[0].due == en_edges);
        chk({tag, ":q_valid"}, q_valid, exp_qv);
        chk({tag, ":count"}, count, sb.size());
        chk({tag, ":busy"}, busy, sb.size() != 0);
        if (exp_qv) chk({tag, ":q"}, q, sb[0].data);
        if (!rst) chk({tag, ":q_reset"}, q, RVAL);
`ifdef D_PIPE_PARITY_EN
        chk({tag, ":par_err"}, par_err, exp_qv && sb[0].pinj);
`endif
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; en = 1'b0; d_valid = 1'b0; d_in = 8'h00;
`ifdef D_PIPE_PARITY_EN
        par_inj = 1'b0;
`endif
        // Reset held for two edges
        step(0, 0, 0, 0, 8'h00, 0, "rst0");
        step(0, 0, 0, 0, 8'h00, 0, "rst1");

        // Streaming: count 1,2,3,3,2,1,0; items out after edges 4,5,6
        step(1, 0, 1, 1, 8'h11, 0, "str1");
        step(1, 0, 1, 1, 8'h22, 0, "str2");
        step(1, 0, 1, 1, 8'h33, 0, "str3");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'h00, 0, "strd");
        chk("str_count_end", count, 0);

        // Stall: 0x11 passes 2 edges, then 3 stalled edges offering 0xFF
        step(1, 0, 1, 1, 8'h11, 0, "stl_in");
        step(1, 0, 1, 0, 8'h00, 0, "stl_adv");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 8'hFF, 0, "stl_hold");
        chk("stl_count_hold", count, 1);
        step(1, 0, 1, 0, 8'h00, 0, "stl_res1");
        step(1, 0, 1, 0, 8'h00, 0, "stl_res2");
        chk("stl_q_out", {q_valid, q}, {1'b1, 8'h11});
        step(1, 0, 1, 0, 8'h00, 0, "stl_drain");

        // Flush with 3 items in flight, 0x77 offered on the flush edge
        step(1, 0, 1, 1, 8'h01, 0, "fl_a");
        step(1, 0, 1, 1, 8'h02, 0, "fl_b");
        step(1, 0, 1, 1, 8'h03, 0, "fl_c");
        step(1, 1, 1, 1, 8'h77, 0, "fl_edge");
        chk("fl_count", count, 0);
        step(1, 0, 1, 1, 8'h88, 0, "fl_88");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'h00, 0, "fl_drain");

        // Priority: reset beats flush and en, then flush beats en
        step(1, 0, 1, 1, 8'h44, 0, "pr_a");
        step(1, 0, 1, 1, 8'h55, 0, "pr_b");
        step(0, 1, 1, 1, 8'h66, 0, "pr_rst");
        step(1, 1, 1, 1, 8'h99, 0, "pr_fl");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'h00, 0, "pr_drain");

        // Full throughput with a stall in the middle of a burst
        for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 8'(8'hB0 + i), 0, "thr");
        step(1, 0, 0, 1, 8'hEE, 0, "thr_stall");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'h00, 0, "thr_drain");

`ifdef D_PIPE_PARITY_EN
        // Parity: only 0xA5 carries an injected error
        step(1, 0, 1, 1, 8'h3C, 0, "par_3c");
        step(1, 0, 1, 1, 8'hA5, 1, "par_a5");
        step(1, 0, 1, 1, 8'hC3, 0, "par_c3");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'h00, 0, "par_drain");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
